// File: rtl/data_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_sram_responder_pkg
// Shared definitions for the data SRAM responder:
//   - request size encodings (byte / half / word)
//   - depth of the in-order response FIFO
//   - width and layout of one response FIFO entry
//   - helper that turns a latency into the countdown load value
// ---------------------------------------------------------------------------
package data_sram_responder_pkg;

  // Size encodings carried on data_sram_size. The responder does not act on
  // them; byte selection is done entirely through wstrb.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Maximum number of accepted-but-unanswered requests.
  localparam int RESP_FIFO_DEPTH = 2;

  // Countdown width covers LAT-1 for LAT up to 7.
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [CNT_W-1:0] countdown;
  } resp_entry_t;

  // The countdown starts at LAT-1 so that a head entry reaches zero
  // LAT-1 edges after acceptance and data_ok is seen at the LAT-th edge.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo2.sv
// ---------------------------------------------------------------------------
// resp_fifo2
// Two-entry in-order response FIFO. Each entry holds the response data and a
// countdown loaded with LAT-1 on push. Countdowns of both entries run in
// parallel, so back-to-back pushes produce back-to-back head_ready cycles.
// The head is popped automatically in the cycle head_ready is high.
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   push_i       in   store push_data_i as a new entry this cycle
//   push_data_i  in   [31:0] data to return with this entry
//   head_ready_o out  head entry's countdown expired; it pops this cycle
//   head_data_o  out  [31:0] head entry data (meaningful with head_ready_o)
//   count_o      out  [1:0] number of entries currently held (0..2)
// ---------------------------------------------------------------------------
module resp_fifo2
  import data_sram_responder_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  output logic        head_ready_o,
  output logic [31:0] head_data_o,
  output logic [1:0]  count_o
);

  localparam logic [CNT_W-1:0] LOAD_CNT = lat_load(LAT);

  resp_entry_t entry_q [RESP_FIFO_DEPTH];
  resp_entry_t entry_d [RESP_FIFO_DEPTH];
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        push_ok;
  logic        pop;

  // Pointers are single bits and simply toggle to wrap. Entries that are not
  // being pushed keep counting down toward zero every cycle; an empty slot
  // parks at zero, which is harmless because push reloads it.
  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    push_ok = push_i && (count_q < 2'(RESP_FIFO_DEPTH));
    pop     = (count_q != 2'd0) && (entry_q[rd_ptr_q].countdown == '0);

    for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
      if (entry_q[i].countdown != '0) begin
        entry_d[i].countdown = entry_q[i].countdown - CNT_W'(1);
      end
    end

    if (push_ok) begin
      entry_d[wr_ptr_q].rdata     = push_data_i;
      entry_d[wr_ptr_q].countdown = LOAD_CNT;
      wr_ptr_d                    = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign head_ready_o = pop;
  assign head_data_o  = entry_q[rd_ptr_q].rdata;
  assign count_o      = count_q;

endmodule

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
// Behavioural data SRAM slave for a CPU data port with a req/addr_ok and
// data_ok handshake. Writes land in memory at acceptance; reads sample memory
// at acceptance. Every accepted request gets exactly one data_ok, LAT cycles
// later, in acceptance order, with at most two requests outstanding.
//
// Parameters:
//   ADDR_W  log2 of memory depth in 32-bit words
//   LAT     acceptance-to-data_ok latency in cycles, 1..7
//
// Ports:
//   clk                in   clock, rising edge
//   resetn             in   asynchronous active-low reset
//   data_sram_req      in   request valid
//   data_sram_wr       in   1 = write, 0 = read
//   data_sram_size     in   [1:0] transfer size (informational only)
//   data_sram_wstrb    in   [3:0] byte-lane write enables
//   data_sram_addr     in   [31:0] byte address
//   data_sram_wdata    in   [31:0] write data
//   data_sram_addr_ok  out  request accepted when high together with req
//   data_sram_data_ok  out  one-cycle response strobe
//   data_sram_rdata    out  [31:0] read data, zero outside data_ok
// ---------------------------------------------------------------------------
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic [31:0]       push_data;
  logic              head_ready;
  logic [31:0]       head_data;
  logic [1:0]        outstanding;
  logic              unused_bits;

  // Only the word index selects a location; the byte offset and the upper
  // address bits are dropped, so addresses alias every 4*DEPTH bytes.
  assign word_idx = data_sram_addr[ADDR_W+1:2];

  // Size is carried on the bus but byte selection relies on wstrb alone.
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2],
                         data_sram_addr[1:0]};

  // addr_ok depends only on the registered occupancy, so a full FIFO stays
  // closed for a cycle even when its head is being returned.
  assign data_sram_addr_ok = (outstanding < 2'(RESP_FIFO_DEPTH));
  assign accept            = data_sram_req && data_sram_addr_ok;

  // A read captures the word as it stands at acceptance, which already
  // includes every earlier accepted write. Writes return zero.
  assign push_data = data_sram_wr ? 32'h0 : mem_q[word_idx];

  // Memory is never reset; its power-up contents are undefined.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  resp_fifo2 #(
    .LAT (LAT)
  ) u_resp_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (accept),
    .push_data_i  (push_data),
    .head_ready_o (head_ready),
    .head_data_o  (head_data),
    .count_o      (outstanding)
  );

  assign data_sram_data_ok = head_ready;
  assign data_sram_rdata   = head_ready ? head_data : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
// Directed bench for data_sram_responder. One instance runs with LAT=2 and a
// second with LAT=1; shared request fields are steered by lat1_sel.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lat1_sel;

  logic        aok_l2, dok_l2, aok_l1, dok_l1;
  logic [31:0] rd_l2, rd_l1;
  logic        aok_s, dok_s;
  logic [31:0] rd_s;

  int checks = 0;
  int errors = 0;

  // Expected tables for the LAT=2 saturation run (one entry per cycle).
  bit sat_aok [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit sat_dok [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int sat_idx [7] = '{-1, 0, 1, -1, 2, 3, -1};
  logic [31:0] sat_w [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

  // Expected tables for the LAT=1 continuous-read run.
  bit l1_dok [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int l1_idx [4] = '{0, 1, 2, -1};
  logic [31:0] l1_w [3] = '{32'h0101_1111, 32'h0202_2222, 32'h0303_3333};

  data_sram_responder #(.ADDR_W(10), .LAT(2)) dut_lat2 (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req && !lat1_sel),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (aok_l2),
    .data_sram_data_ok (dok_l2),
    .data_sram_rdata   (rd_l2)
  );

  data_sram_responder #(.ADDR_W(10), .LAT(1)) dut_lat1 (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (req && lat1_sel),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (aok_l1),
    .data_sram_data_ok (dok_l1),
    .data_sram_rdata   (rd_l1)
  );

  assign aok_s = lat1_sel ? aok_l1 : aok_l2;
  assign dok_s = lat1_sel ? dok_l1 : dok_l2;
  assign rd_s  = lat1_sel ? rd_l1  : rd_l2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advances to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request to the chosen instance, then checks the response
  // arrives exactly LAT cycles after acceptance with the given data.
  task automatic applyStimulus(input bit use_lat1, input logic is_wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] strb,
                               input logic [31:0] exp_rdata, input string tag);
    int lat;
    lat      = use_lat1 ? 1 : 2;
    lat1_sel = use_lat1;
    req      = 1'b1;
    wr       = is_wr;
    addr     = a;
    wdata    = d;
    wstrb    = strb;
    size     = 2'd2;
    checkOutput({tag, ".addr_ok"}, 32'(aok_s), 32'd1);
    stepCycle();
    req = 1'b0;
    for (int i = 0; i < lat - 1; i++) begin
      checkOutput({tag, ".early"}, 32'(dok_s), 32'd0);
      stepCycle();
    end
    checkOutput({tag, ".data_ok"}, 32'(dok_s), 32'd1);
    checkOutput({tag, ".rdata"}, rd_s, exp_rdata);
    stepCycle();
    checkOutput({tag, ".idle_dok"}, 32'(dok_s), 32'd0);
    checkOutput({tag, ".idle_rdata"}, rd_s, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit acc;
    logic [31:0] exp_rd;

    resetn   = 1'b0;
    req      = 1'b0;
    wr       = 1'b0;
    size     = 2'd2;
    wstrb    = 4'h0;
    addr     = 32'h0;
    wdata    = 32'h0;
    lat1_sel = 1'b0;

    // Values held while reset is asserted.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.aok_l2", 32'(aok_l2), 32'd1);
    checkOutput("rst.dok_l2", 32'(dok_l2), 32'd0);
    checkOutput("rst.rd_l2", rd_l2, 32'd0);
    checkOutput("rst.aok_l1", 32'(aok_l1), 32'd1);
    checkOutput("rst.dok_l1", 32'(dok_l1), 32'd0);
    resetn = 1'b1;

    // Write then read back, first request right after reset release.
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr10");
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, "rd10");
    applyStimulus(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEAD_BEEF, "rd13_offset");

    // Byte-lane write, and a zero-strobe write that must change nothing.
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, "wr20_full");
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h0000_AB00, 4'h2, 32'h0, "wr20_lane1");
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_AB44, "rd20_lane");
    applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, "wr20_nostrb");
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_AB44, "rd20_nostrb");

    // Aliasing: 0x1000 maps onto word 0 with ADDR_W=10.
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h5A5A_5A5A, 4'hF, 32'h0, "wr1000");
    applyStimulus(1'b0, 1'b0, 32'h0000, 32'h0, 4'h0, 32'h5A5A_5A5A, "rd0_alias");

    // Saturation with req held high for four reads.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h40 + 32'(4 * i), sat_w[i], 4'hF, 32'h0, "sat_pre");
    end
    lat1_sel = 1'b0;
    wr       = 1'b0;
    req      = 1'b1;
    n        = 0;
    addr     = 32'h40;
    for (int s = 0; s < 7; s++) begin
      acc = req && aok_s;
      stepCycle();
      if (acc) n++;
      if (n == 4) req = 1'b0;
      else addr = 32'h40 + 32'(4 * n);
      exp_rd = (sat_idx[s] < 0) ? 32'h0 : sat_w[sat_idx[s]];
      checkOutput($sformatf("sat%0d.aok", s), 32'(aok_s), 32'(sat_aok[s]));
      checkOutput($sformatf("sat%0d.dok", s), 32'(dok_s), 32'(sat_dok[s]));
      checkOutput($sformatf("sat%0d.rdata", s), rd_s, exp_rd);
    end
    checkOutput("sat.accepts", 32'(n), 32'd4);

    // LAT=1 instance: continuous reads return one cycle after each accept.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(4 * i), l1_w[i], 4'hF, 32'h0, "l1_pre");
    end
    lat1_sel = 1'b1;
    wr       = 1'b0;
    req      = 1'b1;
    n        = 0;
    addr     = 32'h0;
    for (int s = 0; s < 4; s++) begin
      acc = req && aok_s;
      stepCycle();
      if (acc) n++;
      if (n == 3) req = 1'b0;
      else addr = 32'(4 * n);
      exp_rd = (l1_idx[s] < 0) ? 32'h0 : l1_w[l1_idx[s]];
      checkOutput($sformatf("l1_%0d.aok", s), 32'(aok_s), 32'd1);
      checkOutput($sformatf("l1_%0d.dok", s), 32'(dok_s), 32'(l1_dok[s]));
      checkOutput($sformatf("l1_%0d.rdata", s), rd_s, exp_rd);
    end
    checkOutput("l1.accepts", 32'(n), 32'd3);

    // Reset with two reads outstanding on the LAT=2 instance.
    lat1_sel = 1'b0;
    wr       = 1'b0;
    addr     = 32'h10;
    req      = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("mid.pre_dok", 32'(dok_l2), 32'd1);
    checkOutput("mid.pre_aok", 32'(aok_l2), 32'd0);
    req    = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("mid.rst_dok", 32'(dok_l2), 32'd0);
    checkOutput("mid.rst_aok", 32'(aok_l2), 32'd1);
    checkOutput("mid.rst_rd", rd_l2, 32'd0);
    stepCycle();
    resetn = 1'b1;
    for (int s = 0; s < 4; s++) begin
      stepCycle();
      checkOutput($sformatf("mid.post%0d.dok", s), 32'(dok_l2), 32'd0);
      checkOutput($sformatf("mid.post%0d.aok", s), 32'(aok_l2), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, "mid.readback");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
